// File: rtl/apb_mem_bridge.sv
// -----------------------------------------------------------------------------
// apb_mem_bridge
// APB3 slave front-end for a 256x8 synchronous memory. Each APB transfer is
// turned into a single-cycle memory strobe. Read data is captured one clock
// after the read strobe, and pready/pslverr are returned to the APB master.
//
// Optional feature (macro APB_MEM_WPROT_EN):
//   When defined, writes to latched addresses >= WP_BASE are blocked. No strobe
//   is issued and the transfer completes with pslverr=1. When undefined, every
//   address is writable and pslverr stays 0.
//
// Parameters
//   ADDR_W   APB/memory address width
//   DATA_W   APB/memory data width
//   WP_BASE  lowest write-protected address (APB_MEM_WPROT_EN only)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   psel, penable       APB select / access phase
//   pwrite, paddr       APB direction and address
//   pwdata              APB write data
//   prdata              registered read data (holds until the next read)
//   pready, pslverr     transfer complete / transfer error
//   mem_ce              memory chip enable (one cycle per access)
//   mem_rden, mem_wren  memory read / write strobes (never both high)
//   mem_addr            memory address (latched in the setup phase)
//   mem_wr_data         memory write data (latched in the setup phase)
//   mem_rd_data         memory read data, valid the cycle after mem_rden
// -----------------------------------------------------------------------------
module apb_mem_bridge #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter logic [ADDR_W-1:0] WP_BASE = ADDR_W'(8'hF0)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              mem_ce,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state;
  logic   is_write;   // direction latched in the setup phase
  logic   wp_block;   // latched write-protect hit for the current transfer
  logic   setup_c;    // APB setup phase seen while idle
  logic   wp_hit_c;   // setup-phase write targets a protected address

  assign setup_c = psel && !penable;

`ifdef APB_MEM_WPROT_EN
  assign wp_hit_c = pwrite && (paddr >= WP_BASE);
`else
  // Protection disabled: WP_BASE is kept only for a uniform parameter list.
  logic wp_base_unused;
  assign wp_base_unused = ^WP_BASE;
  assign wp_hit_c       = 1'b0;
`endif

  // Transfer sequencer. Strobes and pready are single-cycle pulses, so they
  // are cleared by default every cycle and set only on the entering edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      is_write    <= 1'b0;
      wp_block    <= 1'b0;
      prdata      <= '0;
      pready      <= 1'b0;
      pslverr     <= 1'b0;
      mem_ce      <= 1'b0;
      mem_rden    <= 1'b0;
      mem_wren    <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else begin
      mem_ce   <= 1'b0;
      mem_rden <= 1'b0;
      mem_wren <= 1'b0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;

      case (state)
        // Accept only a proper setup phase; psel+penable here is ignored.
        IDLE: begin
          if (setup_c) begin
            mem_addr    <= paddr;
            mem_wr_data <= pwdata;
            is_write    <= pwrite;
            wp_block    <= wp_hit_c;
            mem_ce      <= !wp_hit_c;
            mem_wren    <= pwrite && !wp_hit_c;
            mem_rden    <= !pwrite;
            state       <= ISSUE;
          end
        end

        // Strobe is on the memory pins during this cycle.
        ISSUE: begin
          if (!psel) begin
            state <= IDLE;
          end else if (is_write) begin
            pready  <= 1'b1;
            pslverr <= wp_block;
            state   <= RESP;
          end else begin
            state <= WAIT;
          end
        end

        // Memory read data is valid now; capture unless the master aborted.
        WAIT: begin
          if (!psel) begin
            state <= IDLE;
          end else begin
            prdata <= mem_rd_data;
            pready <= 1'b1;
            state  <= RESP;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
